// File: rtl/multi_timer_pkg.sv
// Shared register map and parameter limits for the multi-channel cycle timer.
package multi_timer_pkg;

  localparam int OFF_CYCLE   = 'h00;
  localparam int OFF_STATUS  = 'h04;
  localparam int OFF_ENABLE  = 'h08;
  localparam int OFF_CMP0    = 'h10;
  localparam int OFF_PERIOD0 = 'h14;
  localparam int CH_STRIDE   = 8;

  localparam int WIDTH_MIN    = 8;
  localparam int WIDTH_MAX    = 32;
  localparam int CHANNELS_MIN = 1;
  localparam int CHANNELS_MAX = 8;

  function automatic logic [31:0] cmp_offset(input int ch);
    return 32'(OFF_CMP0 + CH_STRIDE * ch);
  endfunction

  function automatic logic [31:0] period_offset(input int ch);
    return 32'(OFF_PERIOD0 + CH_STRIDE * ch);
  endfunction

endpackage

// File: rtl/multi_timer_channel.sv
// One compare channel: compare/period registers, match comparator, reload adder
// and the sticky pending flag.
module multi_timer_channel
  import multi_timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] wdata,
  input  logic             cmp_we,
  input  logic             period_we,
  input  logic             ack,
  output logic             pending,
  output logic [WIDTH-1:0] cmp,
  output logic [WIDTH-1:0] period
);

  logic match;

  assign match = (count == cmp);

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values; the match seen here is always against the old cmp.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cmp     <= '1;
      period  <= '0;
      pending <= 1'b0;
    end else begin
      // A software write to cmp beats the periodic reload.
      if (cmp_we)
        cmp <= wdata;
      else if (match && (period != '0))
        cmp <= cmp + period;

      if (period_we)
        period <= wdata;

      // A new match beats an acknowledge in the same cycle.
      if (match)
        pending <= 1'b1;
      else if (ack)
        pending <= 1'b0;
    end
  end

endmodule

// File: rtl/multi_timer.sv
// Memory-mapped free-running cycle counter with CHANNELS compare channels,
// per-channel interrupt enable and a single ORed interrupt line.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int          CHANNELS  = 4,
  parameter logic [31:0] BASE_ADDR = 32'hffff0100
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         address,
  input  logic [31:0]         data,
  input  logic                MemRead,
  input  logic                MemWrite,
  output logic [31:0]         rdata,
  output logic                TimerAddress,
  output logic                TimerInterrupt,
  output logic [CHANNELS-1:0] irq_pending
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
      CHANNELS < CHANNELS_MIN || CHANNELS > CHANNELS_MAX) begin : g_bad_params
    $error("multi_timer: WIDTH or CHANNELS out of range");
  end

  logic [31:0]         offset;
  logic                cycle_hit, status_hit, enable_hit;
  logic [CHANNELS-1:0] cmp_hit, period_hit;
  logic                wr;
  logic [WIDTH-1:0]    count;
  logic [CHANNELS-1:0] enable;
  logic [WIDTH-1:0]    cmp_val    [CHANNELS];
  logic [WIDTH-1:0]    period_val [CHANNELS];

  // Addresses below BASE_ADDR wrap to huge offsets and miss every slot.
  assign offset     = address - BASE_ADDR;
  assign cycle_hit  = (offset == 32'(OFF_CYCLE));
  assign status_hit = (offset == 32'(OFF_STATUS));
  assign enable_hit = (offset == 32'(OFF_ENABLE));

  assign TimerAddress = cycle_hit | status_hit | enable_hit | (|cmp_hit) | (|period_hit);
  assign wr           = MemWrite & TimerAddress;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign cmp_hit[i]    = (offset == cmp_offset(i));
    assign period_hit[i] = (offset == period_offset(i));

    multi_timer_channel #(.WIDTH(WIDTH)) u_channel (
      .clock     (clock),
      .reset     (reset),
      .count     (count),
      .wdata     (data[WIDTH-1:0]),
      .cmp_we    (wr & cmp_hit[i]),
      .period_we (wr & period_hit[i]),
      .ack       (wr & status_hit & data[i]),
      .pending   (irq_pending[i]),
      .cmp       (cmp_val[i]),
      .period    (period_val[i])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count  <= '0;
      enable <= '0;
    end else begin
      if (wr && cycle_hit)
        count <= data[WIDTH-1:0];
      else
        count <= count + WIDTH'(1);

      if (wr && enable_hit)
        enable <= data[CHANNELS-1:0];
    end
  end

  assign TimerInterrupt = |(irq_pending & enable);

  // NOTE: rdata gets a default before any branch so the read mux never
  // infers a latch; unused upper bits stay zero for narrow registers.
  always_comb begin
    rdata = '0;
    if (MemRead && TimerAddress) begin
      if (cycle_hit)  rdata[WIDTH-1:0]    = count;
      if (status_hit) rdata[CHANNELS-1:0] = irq_pending;
      if (enable_hit) rdata[CHANNELS-1:0] = enable;
      for (int i = 0; i < CHANNELS; i++) begin
        if (cmp_hit[i])    rdata[WIDTH-1:0] = cmp_val[i];
        if (period_hit[i]) rdata[WIDTH-1:0] = period_val[i];
      end
    end
  end

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: directed scenarios plus random bus
// traffic, all compared against a register-level behavioural model.
module tb_multi_timer;

  localparam logic [31:0] BASE = 32'hffff0100;
  localparam int          CH   = 4;
  localparam logic [31:0] IDLE = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] address, data, rdata;
  logic        MemRead, MemWrite, TimerAddress, TimerInterrupt;
  logic [CH-1:0] irq_pending;

  logic [31:0] address8, data8, rdata8;
  logic        MemRead8, MemWrite8, TimerAddress8, TimerInterrupt8;
  logic [1:0]  irq_pending8;

  always #5 clock = ~clock;

  multi_timer dut (
    .clock(clock), .reset(reset), .address(address), .data(data),
    .MemRead(MemRead), .MemWrite(MemWrite), .rdata(rdata),
    .TimerAddress(TimerAddress), .TimerInterrupt(TimerInterrupt),
    .irq_pending(irq_pending)
  );

  multi_timer #(.WIDTH(8), .CHANNELS(2), .BASE_ADDR(BASE)) dut8 (
    .clock(clock), .reset(reset), .address(address8), .data(data8),
    .MemRead(MemRead8), .MemWrite(MemWrite8), .rdata(rdata8),
    .TimerAddress(TimerAddress8), .TimerInterrupt(TimerInterrupt8),
    .irq_pending(irq_pending8)
  );

  int checks   = 0;
  int failures = 0;

  // Register-level model of the 32-bit, 4-channel instance.
  logic [31:0]   m_count;
  logic [31:0]   m_cmp    [CH];
  logic [31:0]   m_period [CH];
  logic [CH-1:0] m_pend, m_en;

  logic [31:0] last_rdata, last_rdata8;
  logic        last_ta;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0;
    m_pend  = '0;
    m_en    = '0;
    for (int i = 0; i < CH; i++) begin
      m_cmp[i]    = 32'hffff_ffff;
      m_period[i] = 0;
    end
  endtask

  function automatic void model_read(input logic [31:0] a, output bit hit, output logic [31:0] v);
    logic [31:0] off;
    off = a - BASE;
    hit = 1'b1;
    v   = 0;
    if (off == 0)      v = m_count;
    else if (off == 4) v = {28'b0, m_pend};
    else if (off == 8) v = {28'b0, m_en};
    else if (off >= 16 && off < 16 + 8 * CH && off[1:0] == 2'b00)
      v = off[2] ? m_period[(off - 16) / 8] : m_cmp[(off - 16) / 8];
    else
      hit = 1'b0;
  endfunction

  // Next state from the current one and this cycle's bus access.
  task automatic model_apply(input bit wr, input logic [31:0] a, input logic [31:0] d);
    logic [31:0]   off, dummy, n_count;
    logic [31:0]   n_cmp [CH];
    logic [31:0]   n_per [CH];
    logic [CH-1:0] match, n_pend, n_en;
    bit            hit;
    model_read(a, hit, dummy);
    off = a - BASE;
    for (int i = 0; i < CH; i++) match[i] = (m_count == m_cmp[i]);
    n_count = m_count + 1;
    n_pend  = m_pend | match;
    n_en    = m_en;
    n_cmp   = m_cmp;
    n_per   = m_period;
    for (int i = 0; i < CH; i++)
      if (match[i] && m_period[i] != 0) n_cmp[i] = m_cmp[i] + m_period[i];
    if (wr && hit) begin
      if (off == 0)      n_count = d;
      else if (off == 4) n_pend  = (m_pend & ~d[CH-1:0]) | match;
      else if (off == 8) n_en    = d[CH-1:0];
      else if (off[2])   n_per[(off - 16) / 8] = d;
      else               n_cmp[(off - 16) / 8] = d;
    end
    m_count  = n_count;
    m_pend   = n_pend;
    m_en     = n_en;
    m_cmp    = n_cmp;
    m_period = n_per;
  endtask

  // One bus cycle on the main instance, starting and ending at a falling edge.
  task automatic tick(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
    bit          hit;
    logic [31:0] v;
    address  = a;
    data     = d;
    MemWrite = wr;
    MemRead  = rd;
    #1;
    model_read(a, hit, v);
    last_rdata = rdata;
    last_ta    = TimerAddress;
    check("addr_decode", 32'(TimerAddress), 32'(hit));
    check("rdata", rdata, (rd && hit) ? v : 32'h0);
    model_apply(wr, a, d);
    @(posedge clock);
    @(negedge clock);
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    check("irq_pending", 32'(irq_pending), 32'(m_pend));
    check("irq_line", 32'(TimerInterrupt), 32'(|(m_pend & m_en)));
  endtask

  task automatic wr32(input logic [31:0] off, input logic [31:0] d);
    tick(1'b1, 1'b0, BASE + off, d);
  endtask

  task automatic rd32(input logic [31:0] off);
    tick(1'b0, 1'b1, BASE + off, 32'h0);
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, IDLE, 32'h0);
  endtask

  // One bus cycle on the 8-bit instance while the main instance idles.
  task automatic tick8(input bit wr, input bit rd, input logic [31:0] off, input logic [31:0] d);
    address8  = BASE + off;
    data8     = d;
    MemWrite8 = wr;
    MemRead8  = rd;
    #1;
    last_rdata8 = rdata8;
    tick(1'b0, 1'b0, IDLE, 32'h0);
    MemWrite8 = 1'b0;
    MemRead8  = 1'b0;
  endtask

  initial begin
    int op, ch;
    reset = 1'b1;
    address = IDLE;  data = 0;  MemRead = 0;  MemWrite = 0;
    address8 = IDLE; data8 = 0; MemRead8 = 0; MemWrite8 = 0;
    #1;
    check("reset_irq", 32'(TimerInterrupt), 32'd0);
    check("reset_pending", 32'(irq_pending), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();

    // Idle after reset, then read the counter and reset values.
    repeat (10) idle();
    rd32(32'h00); check("cycle_after_10", last_rdata, 32'd10);
    rd32(32'h04); check("status_reset", last_rdata, 32'd0);
    rd32(32'h10); check("cmp0_reset", last_rdata, 32'hffff_ffff);

    // One-shot match on channel 1, then acknowledge.
    wr32(32'h18, 32'd50);
    wr32(32'h08, 32'h2);
    for (int n = 0; n < 80 && !irq_pending[1]; n++) idle();
    check("ch1_pending_seen", 32'(irq_pending[1]), 32'd1);
    check("ch1_irq_seen", 32'(TimerInterrupt), 32'd1);
    rd32(32'h00); check("ch1_match_count", last_rdata, 32'd51);
    wr32(32'h04, 32'h2);
    check("ch1_ack_pending", 32'(irq_pending[1]), 32'd0);
    check("ch1_ack_irq", 32'(TimerInterrupt), 32'd0);
    repeat (20) idle();
    check("ch1_no_retrigger", 32'(irq_pending[1]), 32'd0);

    // Periodic channel 0: matches at 20, 36, 52, 68.
    wr32(32'h00, 32'd0);
    wr32(32'h10, 32'd20);
    wr32(32'h14, 32'd16);
    wr32(32'h08, 32'h1);
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 40 && !irq_pending[0]; n++) idle();
      check("ch0_period_pending", 32'(irq_pending[0]), 32'd1);
      rd32(32'h00); check("ch0_period_count", last_rdata, 32'(21 + 16 * k));
      wr32(32'h04, 32'h1);
    end
    rd32(32'h10); check("ch0_reloaded_cmp", last_rdata, 32'd84);

    // Same-cycle collisions: ack vs match on ch2, cmp write vs match on ch3.
    wr32(32'h00, 32'd100);
    wr32(32'h20, 32'd110);
    wr32(32'h28, 32'd120);
    for (int n = 0; n < 40 && m_count != 110; n++) idle();
    wr32(32'h04, 32'h4);
    check("ch2_set_beats_ack", 32'(irq_pending[2]), 32'd1);
    for (int n = 0; n < 40 && m_count != 120; n++) idle();
    wr32(32'h28, 32'h1234);
    check("ch3_match_on_write", 32'(irq_pending[3]), 32'd1);
    rd32(32'h28); check("ch3_new_cmp", last_rdata, 32'h1234);

    // 8-bit instance: wrap fe, ff, 00, 01 and zero-extended reads.
    tick8(1'b1, 1'b0, 32'h00, 32'h10);
    tick8(1'b1, 1'b0, 32'h10, 32'h01);
    tick8(1'b1, 1'b0, 32'h04, 32'h03);
    check("w8_ack", 32'(irq_pending8[0]), 32'd0);
    tick8(1'b1, 1'b0, 32'h00, 32'hfe);
    repeat (3) tick8(1'b0, 1'b0, 32'h0c, 32'h0);
    check("w8_no_early", 32'(irq_pending8[0]), 32'd0);
    tick8(1'b0, 1'b1, 32'h00, 32'h0);
    check("w8_cycle_zero_ext", last_rdata8, 32'h0000_0001);
    check("w8_wrap_match", 32'(irq_pending8[0]), 32'd1);
    tick8(1'b0, 1'b1, 32'h10, 32'h0);
    check("w8_cmp_zero_ext", last_rdata8, 32'h0000_0001);

    // Reset mid-operation with the interrupt line high.
    wr32(32'h08, 32'hc);
    check("irq_before_reset", 32'(TimerInterrupt), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("irq_async_drop", 32'(TimerInterrupt), 32'd0);
    check("pending_async_clear", 32'(irq_pending), 32'd0);
    check("w8_async_clear", {30'b0, irq_pending8}, 32'd0);
    check("w8_irq_async_drop", 32'(TimerInterrupt8), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    rd32(32'h04); check("status_after_reset", last_rdata, 32'd0);
    rd32(32'h08); check("enable_after_reset", last_rdata, 32'd0);
    for (int i = 0; i < CH; i++) begin
      rd32(32'(16 + 8 * i)); check("cmp_after_reset", last_rdata, 32'hffff_ffff);
      rd32(32'(20 + 8 * i)); check("period_after_reset", last_rdata, 32'd0);
    end
    rd32(32'h0c);
    check("hole_0c_addr", 32'(last_ta), 32'd0);
    check("hole_0c_rdata", last_rdata, 32'd0);
    wr32(32'h0c, 32'hdead_beef);

    // Random bus traffic against the model.
    for (int n = 0; n < 600; n++) begin
      op = $urandom_range(0, 11);
      ch = $urandom_range(0, CH - 1);
      case (op)
        4, 5:  wr32(32'(16 + 8 * ch), m_count + $urandom_range(0, 24));
        6:     wr32(32'(20 + 8 * ch), ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom_range(1, 12));
        7:     wr32(32'h04, $urandom);
        8:     wr32(32'h08, $urandom);
        9, 10: rd32(32'(4 * $urandom_range(0, 15)));
        11: begin
          if ($urandom_range(0, 3) == 0) wr32(32'h00, $urandom);
          else tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
        end
        default: idle();
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
# multi_timer

Memory-mapped, multi-channel cycle timer for the processor's data-memory bus. A free-running WIDTH-bit cycle counter is compared against CHANNELS independent compare registers. Each channel latches a pending interrupt on match and can auto-reload for periodic operation. The enabled pending bits are ORed onto one interrupt line for the CPU's interrupt logic, and the block asserts TimerAddress so the memory system steers the access here.

## Interface
- WIDTH, 32: counter/compare width, 8..32; bus reads zero-extend, bus writes take data[WIDTH-1:0]
- CHANNELS, 4: number of compare channels, 1..8
- BASE_ADDR, 32'hffff0100: word-aligned base of the register window

One clock; reset is asynchronous and active-high.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- address  in  32  bus byte address, full 32-bit decode
- data  in  32  bus write data
- MemRead  in  1  bus read strobe
- MemWrite  in  1  bus write strobe
- rdata  out  32  read data; combinational; 0 unless MemRead and TimerAddress
- TimerAddress  out  1  address hits a mapped register (independent of strobes)
- TimerInterrupt  out  1  |(pending & enable)
- irq_pending  out  CHANNELS  raw pending bits, for debug and bench

## Operation
- Register map, offsets from BASE_ADDR:
  - 0x00 CYCLE: R = count; W loads count
  - 0x04 STATUS: R = pending; W1C acknowledge, bit i clears pending[i]
  - 0x08 ENABLE: RW per-channel interrupt enable
  - 0x10+8i CMP_i: RW compare value
  - 0x14+8i PERIOD_i: RW reload step; 0 = one-shot
- Any other offset, including unused channel slots, is unmapped: TimerAddress=0, writes ignored, rdata=0.
- Counter: count <= count+1 each cycle, wrapping mod 2^WIDTH. A CYCLE write replaces the increment: count <= data.
- Match: match_i = (count == CMP_i), evaluated on current register values. On match, pending[i] <= 1 at the next edge.
- Periodic reload: if match_i and PERIOD_i != 0, then CMP_i <= CMP_i + PERIOD_i, mod 2^WIDTH.
- Pending ignores ENABLE. Enabling a channel that is already pending raises TimerInterrupt immediately.
- Simultaneous events:
  - match_i and STATUS W1C of bit i in the same cycle: set wins, pending stays 1.
  - match_i and CMP_i write in the same cycle: match uses the old value, then CMP_i takes the bus data. Software write beats periodic reload.
  - CYCLE write and match in the same cycle: match uses the pre-write count.
- STATUS/ENABLE bits at or above CHANNELS read as 0 and ignore writes.

## Timing
- Reset values: count=0, CMP_i=all ones, PERIOD_i=0, pending=0, ENABLE=0. Outputs after reset: TimerInterrupt=0, irq_pending=0.
- Reset mid-operation clears all state asynchronously; TimerInterrupt drops without waiting for a clock edge.
- Read latency 0: rdata is valid in the same cycle as MemRead.
- Write latency 1: the value is visible from the next edge.
- Interrupt latency: count==CMP_i during cycle t gives pending[i]=1 and TimerInterrupt=1 (if enabled) from the edge ending t.
- Acknowledge: a W1C in cycle t clears pending at the edge ending t.
- With PERIOD_i=P, matches repeat every P cycles with no drift.

## Structure
- Shared header (existing `define include style): register offsets, WIDTH/CHANNELS limits.
- Sub-module timer_channel: CMP/PERIOD registers, match comparator, reload adder, pending flop.
  - Inputs: count, write enables for CMP/PERIOD, ack bit.
  - Outputs: pending, match, register read values.
- Top level holds the counter, the address decoder, the ENABLE register and the read mux.

## Test plan
- Reset, idle 10 cycles -> TimerInterrupt=0; CYCLE read returns 10 (±bus cycle); STATUS=0; CMP_0 read = 32'hffffffff.
- Write CMP_1=50, ENABLE=4'b0010 -> pending[1] and TimerInterrupt rise at the edge after count==50. Write STATUS=4'b0010 -> both clear next edge. No re-trigger until wrap.
- CMP_0=20, PERIOD_0=16, enable ch0, ack each time -> pending sets after counts 20, 36, 52, 68; CMP_0 reads 84 after the fourth match.
- W1C bit 2 in the exact cycle count==CMP_2 -> pending[2] remains 1. CMP_3 write in its match cycle -> pending[3] sets and CMP_3 holds the new value.
- WIDTH=8: CYCLE write 8'hfe, CMP_0=1 -> count wraps fe,ff,00,01; pending[0] sets. CYCLE read returns 32'h00000001 zero-extended.
- Assert reset while TimerInterrupt=1 mid-period -> TimerInterrupt=0 asynchronously. After release all registers are at reset values, and access to BASE+0x0c gives TimerAddress=0, rdata=0.
